// File: rtl/msx_bus_pkg.sv
// Shared types and decode helpers for the MSX slot bus initiator.
package msx_bus_pkg;

  localparam int R_CNT_W = 7;

  typedef enum logic [2:0] {
    CMD_MEM_RD = 3'd0,
    CMD_MEM_WR = 3'd1,
    CMD_IO_RD  = 3'd2,
    CMD_IO_WR  = 3'd3,
    CMD_M1     = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, T1, T2, TWA, TW, T3, T3R, T4R
  } state_t;

  // All active-low bus strobes, bundled so one register holds them.
  typedef struct packed {
    logic merq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic m1_n;
    logic rfsh_n;
    logic sltsl_n;
    logic cs1_n;
    logic cs2_n;
    logic cs12_n;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '1;

  function automatic logic is_io(cmd_t cmd);
    return (cmd == CMD_IO_RD) || (cmd == CMD_IO_WR);
  endfunction

  // Successor of a bus state, evaluated only on a tick.
  function automatic state_t next_state(state_t st, cmd_t cmd, logic wait_n, logic limit_hit);
    state_t data_st;
    state_t nxt;
    data_st = (cmd == CMD_M1) ? T3R : T3;
    case (st)
      IDLE:    nxt = T1;
      T1:      nxt = T2;
      T2:      nxt = is_io(cmd) ? TWA : (!wait_n ? TW : data_st);
      TWA:     nxt = !wait_n ? TW : T3;
      TW:      nxt = (!wait_n && !limit_hit) ? TW : data_st;
      T3:      nxt = IDLE;
      T3R:     nxt = T4R;
      T4R:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  // Strobe levels to present while the bus sits in state st.
  function automatic strobes_t strobes_for(state_t st, cmd_t cmd, logic slot, logic [15:0] addr);
    strobes_t s;
    logic     fetch_ph;
    logic     io_ph;
    s        = STROBES_IDLE;
    fetch_ph = (st == T1) || (st == T2) || (st == TW) || (st == T3);
    io_ph    = (st == T2) || (st == TWA) || (st == TW) || (st == T3);
    if (is_io(cmd)) begin
      if (io_ph) begin
        s.iorq_n = 1'b0;
        s.rd_n   = (cmd != CMD_IO_RD);
        s.wr_n   = (cmd != CMD_IO_WR);
      end
    end else if (fetch_ph) begin
      s.merq_n  = 1'b0;
      s.sltsl_n = ~slot;
      s.cs1_n   = (addr[15:14] != 2'b01);
      s.cs2_n   = (addr[15:14] != 2'b10);
      s.cs12_n  = s.cs1_n & s.cs2_n;
      s.rd_n    = !((cmd == CMD_MEM_RD) || (cmd == CMD_M1));
      s.wr_n    = !((cmd == CMD_MEM_WR) && (st != T1));
      s.m1_n    = (cmd != CMD_M1);
    end else if (st == T3R) begin
      s.merq_n = 1'b0;
      s.rfsh_n = 1'b0;
    end else if (st == T4R) begin
      s.rfsh_n = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/msx_bus_if.sv
// MSX slot bus signal bundle; MSX side initiates, CART side responds.
interface BUS_IF;
  logic [15:0] ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic        MERQ_n;
  logic        IORQ_n;
  logic        RD_n;
  logic        WR_n;
  logic        M1_n;
  logic        RFSH_n;
  logic        SLTSL_n;
  logic        CS1_n;
  logic        CS2_n;
  logic        CS12_n;
  logic        WAIT_n;
  logic        RESET_n;
  logic        CLK;
  logic        CLK_EN;
  logic        CLK_21M;
  logic        CLK_14M;
  logic        CLK_EN_21M;

  modport MSX (
    output ADDR, DIN, MERQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n,
    output SLTSL_n, CS1_n, CS2_n, CS12_n, RESET_n,
    output CLK, CLK_EN, CLK_21M, CLK_14M, CLK_EN_21M,
    input  DOUT, WAIT_n
  );

  modport CART (
    input  ADDR, DIN, MERQ_n, IORQ_n, RD_n, WR_n, M1_n, RFSH_n,
    input  SLTSL_n, CS1_n, CS2_n, CS12_n, RESET_n,
    input  CLK, CLK_EN, CLK_21M, CLK_14M, CLK_EN_21M,
    output DOUT, WAIT_n
  );
endinterface

// File: rtl/msx_tick_gen.sv
// T-state timebase: one-cycle tick per CLK_DIV clocks plus the bus clock.
module msx_tick_gen #(
  parameter int CLK_DIV = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o,
  output logic bus_clk_o
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          bclk_q;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  // Period counter; tick marks the first cycle of a period, bus clock is high for the first half.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
      bclk_q <= (cnt_d < HALF);
    end
  end

  assign tick_o    = tick_q;
  assign bus_clk_o = bclk_q;

endmodule

// File: rtl/msx_bus_initiator.sv
// Host-side MSX slot bus initiator: turns single commands into Z80-timed bus cycles.
module msx_bus_initiator
  import msx_bus_pkg::*;
#(
  parameter int CLK_DIV    = 6,
  parameter int WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SOFT_RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [2:0]  REQ_CMD,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  input  logic        REQ_SLOT,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_TIMEOUT,
  BUS_IF.MSX          Bus
);

  localparam logic [7:0] WLIM = 8'(WAIT_LIMIT);

  logic               tick;
  logic               bus_clk;
  state_t             state_q;
  state_t             state_d;
  cmd_t               cmd_q;
  logic [15:0]        areq_q;
  logic [7:0]         wdata_q;
  logic               slot_q;
  logic               pending_q;
  logic [7:0]         wcnt_q;
  logic               timeout_q;
  logic [R_CNT_W-1:0] r_cnt_q;
  logic [7:0]         data_q;
  logic [15:0]        addr_q;
  logic [7:0]         din_q;
  strobes_t           strb_q;
  logic               rst_n_q;
  logic               ready_q;
  logic               rsp_valid_q;
  logic [7:0]         rsp_rdata_q;
  logic               rsp_timeout_q;

  msx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .tick_o    (tick),
    .bus_clk_o (bus_clk)
  );

  assign state_d = next_state(state_q, cmd_q, Bus.WAIT_n, wcnt_q >= WLIM);

  // Bus cycle FSM with registered strobes, address, data and response.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      cmd_q         <= CMD_MEM_RD;
      areq_q        <= '0;
      wdata_q       <= '0;
      slot_q        <= 1'b0;
      pending_q     <= 1'b0;
      wcnt_q        <= '0;
      timeout_q     <= 1'b0;
      r_cnt_q       <= '0;
      data_q        <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      strb_q        <= STROBES_IDLE;
      rst_n_q       <= 1'b0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (SOFT_RESET) begin
      // Abort whatever is in flight without a response; address and data lines hold.
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      wcnt_q        <= '0;
      timeout_q     <= 1'b0;
      strb_q        <= STROBES_IDLE;
      rst_n_q       <= 1'b0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rst_n_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (pending_q) begin
          if (tick) begin
            state_q   <= T1;
            strb_q    <= strobes_for(T1, cmd_q, slot_q, areq_q);
            addr_q    <= areq_q;
            din_q     <= (cmd_q == CMD_MEM_WR || cmd_q == CMD_IO_WR) ? wdata_q : 8'h00;
            pending_q <= 1'b0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
          end
        end else if (REQ_VALID && ready_q) begin
          cmd_q     <= cmd_t'(REQ_CMD);
          areq_q    <= REQ_ADDR;
          wdata_q   <= REQ_WDATA;
          slot_q    <= REQ_SLOT;
          pending_q <= 1'b1;
          ready_q   <= 1'b0;
        end else begin
          ready_q <= 1'b1;
        end
      end else if (tick) begin
        state_q <= state_d;
        strb_q  <= strobes_for(state_d, cmd_q, slot_q, areq_q);
        if (state_d == TW) begin
          wcnt_q <= (state_q == TW) ? wcnt_q + 8'd1 : 8'd1;
        end else begin
          wcnt_q <= '0;
        end
        // Leaving TW while WAIT_n is still low can only mean the limit was hit.
        if (state_q == TW && state_d != TW && !Bus.WAIT_n) begin
          timeout_q <= 1'b1;
        end
        if (state_d == T3R) begin
          addr_q <= {{(16 - R_CNT_W){1'b0}}, r_cnt_q};
          data_q <= Bus.DOUT;
        end
        if (state_q == T4R) begin
          r_cnt_q <= r_cnt_q + 1'b1;
        end
        if (state_d == IDLE) begin
          rsp_valid_q   <= 1'b1;
          ready_q       <= 1'b1;
          rsp_timeout_q <= timeout_q || (state_q == TW);
          timeout_q     <= 1'b0;
          case (cmd_q)
            CMD_MEM_RD, CMD_IO_RD: rsp_rdata_q <= Bus.DOUT;
            CMD_M1:                rsp_rdata_q <= data_q;
            default:               rsp_rdata_q <= 8'h00;
          endcase
        end
      end
    end
  end

  assign REQ_READY   = ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

  assign Bus.ADDR       = addr_q;
  assign Bus.DIN        = din_q;
  assign Bus.MERQ_n     = strb_q.merq_n;
  assign Bus.IORQ_n     = strb_q.iorq_n;
  assign Bus.RD_n       = strb_q.rd_n;
  assign Bus.WR_n       = strb_q.wr_n;
  assign Bus.M1_n       = strb_q.m1_n;
  assign Bus.RFSH_n     = strb_q.rfsh_n;
  assign Bus.SLTSL_n    = strb_q.sltsl_n;
  assign Bus.CS1_n      = strb_q.cs1_n;
  assign Bus.CS2_n      = strb_q.cs2_n;
  assign Bus.CS12_n     = strb_q.cs12_n;
  assign Bus.RESET_n    = rst_n_q;
  assign Bus.CLK        = bus_clk;
  assign Bus.CLK_EN     = tick;
  assign Bus.CLK_21M    = CLK;
  assign Bus.CLK_14M    = CLK;
  assign Bus.CLK_EN_21M = 1'b1;

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Directed bench for msx_bus_initiator with a small cartridge-side responder.
module tb_msx_bus_initiator;
  import msx_bus_pkg::*;

  localparam int D  = 4;
  localparam int WL = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SOFT_RESET = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [2:0]  REQ_CMD = 3'd0;
  logic [15:0] REQ_ADDR = 16'h0000;
  logic [7:0]  REQ_WDATA = 8'h00;
  logic        REQ_SLOT = 1'b0;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic        RSP_TIMEOUT;

  BUS_IF bus_if ();

  msx_bus_initiator #(.CLK_DIV(D), .WAIT_LIMIT(WL)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .SOFT_RESET  (SOFT_RESET),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_CMD     (REQ_CMD),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .REQ_SLOT    (REQ_SLOT),
    .RSP_VALID   (RSP_VALID),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_TIMEOUT (RSP_TIMEOUT),
    .Bus         (bus_if)
  );

  always #5 CLK = ~CLK;

  // Cartridge responder: fixed data, a megarom bank register at 0x6000, and WAIT_n insertion.
  logic [7:0] fixed_dout = 8'hA5;
  logic       mega_en = 1'b0;
  logic [7:0] bank = 8'h00;
  int         wait_cfg = 0;
  logic       wait_stuck = 1'b0;
  int         tcnt = 0;

  always @(posedge CLK) begin
    if (!bus_if.WR_n && !bus_if.MERQ_n && !bus_if.SLTSL_n && bus_if.ADDR[15:11] == 5'b01100)
      bank <= bus_if.DIN;
    if (bus_if.MERQ_n) tcnt <= 0;
    else if (bus_if.CLK_EN) tcnt <= tcnt + 1;
  end

  assign bus_if.DOUT   = (mega_en && bus_if.ADDR[15:13] == 3'b010) ? {bank[3:0], bus_if.ADDR[3:0]} : fixed_dout;
  assign bus_if.WAIT_n = wait_stuck ? 1'b0 : !(wait_cfg != 0 && tcnt >= 1 && tcnt <= wait_cfg);

  int n_pass = 0;
  int n_checks = 0;
  int n_fail = 0;

  int c_merq, c_iorq, c_rd, c_wr, c_sltsl, c_cs1, c_m1, c_rfsh;
  logic [15:0] rfsh_addr;
  bit          rfsh_seen;
  int          lat;
  logic [7:0]  rdata;
  logic        tmo;
  bit          got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample_bus();
    if (!bus_if.MERQ_n)  c_merq++;
    if (!bus_if.IORQ_n)  c_iorq++;
    if (!bus_if.RD_n)    c_rd++;
    if (!bus_if.WR_n)    c_wr++;
    if (!bus_if.SLTSL_n) c_sltsl++;
    if (!bus_if.CS1_n)   c_cs1++;
    if (!bus_if.M1_n)    c_m1++;
    if (!bus_if.RFSH_n) begin
      if (!rfsh_seen) rfsh_addr = bus_if.ADDR;
      rfsh_seen = 1'b1;
      c_rfsh++;
    end
  endtask

  // Present a request in a tick cycle so acceptance latency is deterministic.
  task automatic start_txn(input logic [2:0] cmd, input logic [15:0] addr,
                           input logic [7:0] wd, input logic slot);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!(bus_if.CLK_EN && REQ_READY) && guard < 64) begin
      @(negedge CLK);
      guard++;
    end
    chk("ready_before_req", REQ_READY, 1);
    REQ_CMD   = cmd;
    REQ_ADDR  = addr;
    REQ_WDATA = wd;
    REQ_SLOT  = slot;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    c_merq = 0; c_iorq = 0; c_rd = 0; c_wr = 0;
    c_sltsl = 0; c_cs1 = 0; c_m1 = 0; c_rfsh = 0;
    rfsh_seen = 1'b0;
    rfsh_addr = 16'hFFFF;
    lat = 1;
    got = 1'b0;
    sample_bus();
  endtask

  task automatic finish_txn();
    while (!got && lat < 300) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      sample_bus();
      if (RSP_VALID) begin
        got   = 1'b1;
        rdata = RSP_RDATA;
        tmo   = RSP_TIMEOUT;
      end
    end
    chk("rsp_seen", got, 1);
    $display("txn cmd=%0d addr=%h lat=%0d rdata=%h tmo=%0b rfsh_addr=%h",
             REQ_CMD, REQ_ADDR, lat, rdata, tmo, rfsh_addr);
  endtask

  task automatic run_txn(input logic [2:0] cmd, input logic [15:0] addr,
                         input logic [7:0] wd, input logic slot);
    start_txn(cmd, addr, wd, slot);
    finish_txn();
  endtask

  function automatic logic [9:0] all_strobes();
    return {bus_if.MERQ_n, bus_if.IORQ_n, bus_if.RD_n, bus_if.WR_n, bus_if.M1_n,
            bus_if.RFSH_n, bus_if.SLTSL_n, bus_if.CS1_n, bus_if.CS2_n, bus_if.CS12_n};
  endfunction

  initial begin
    int guard;
    int rsp_cnt;

    // Reset state
    @(negedge CLK);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_strobes", all_strobes(), 10'h3FF);
    chk("rst_addr", bus_if.ADDR, 16'h0000);
    chk("rst_reset_n", bus_if.RESET_n, 0);
    chk("rst_clk_en", bus_if.CLK_EN, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_ready", REQ_READY, 1);
    chk("post_rst_reset_n", bus_if.RESET_n, 1);

    // Memory read, slot asserted, page 1
    run_txn(CMD_MEM_RD, 16'h4000, 8'h00, 1'b1);
    chk("mrd_lat", lat, 4 * D + 1);
    chk("mrd_rdata", rdata, 8'hA5);
    chk("mrd_merq", c_merq, 3 * D);
    chk("mrd_sltsl", c_sltsl, 3 * D);
    chk("mrd_rd", c_rd, 3 * D);
    chk("mrd_cs1", c_cs1, 3 * D);
    chk("mrd_wr", c_wr, 0);
    chk("mrd_tmo", tmo, 0);

    // Megarom bank switch then read of bank 5 byte 0
    run_txn(CMD_MEM_WR, 16'h6000, 8'h05, 1'b1);
    chk("mwr_wr", c_wr, 2 * D);
    chk("mwr_merq", c_merq, 3 * D);
    chk("mwr_rdata", rdata, 8'h00);
    chk("mwr_lat", lat, 4 * D + 1);
    mega_en = 1'b1;
    run_txn(CMD_MEM_RD, 16'h4000, 8'h00, 1'b1);
    chk("bank5_rdata", rdata, 8'h50);
    mega_en = 1'b0;

    // Three external waits
    wait_cfg = 3;
    run_txn(CMD_MEM_RD, 16'h8000, 8'h00, 1'b0);
    chk("wait_lat", lat, 4 * D + 1 + 3 * D);
    chk("wait_tmo", tmo, 0);
    chk("wait_sltsl", c_sltsl, 0);
    chk("wait_rd", c_rd, 6 * D);
    wait_cfg = 0;

    // WAIT_n stuck low: abort after WAIT_LIMIT waits
    wait_stuck = 1'b1;
    run_txn(CMD_MEM_RD, 16'h0000, 8'h00, 1'b1);
    chk("tmo_lat", lat, 4 * D + 1 + WL * D);
    chk("tmo_flag", tmo, 1);
    chk("tmo_strobes_after", all_strobes(), 10'h3FF);
    wait_stuck = 1'b0;

    // I/O read of VDP port
    fixed_dout = 8'h77;
    run_txn(CMD_IO_RD, 16'h0098, 8'h00, 1'b1);
    chk("io_lat", lat, 5 * D + 1);
    chk("io_iorq", c_iorq, 3 * D);
    chk("io_rd", c_rd, 3 * D);
    chk("io_sltsl", c_sltsl, 0);
    chk("io_merq", c_merq, 0);
    chk("io_rdata", rdata, 8'h77);

    // Two M1 cycles with refresh
    fixed_dout = 8'h3E;
    run_txn(CMD_M1, 16'h1234, 8'h00, 1'b1);
    chk("m1a_lat", lat, 5 * D + 1);
    chk("m1a_rfsh_addr", rfsh_addr, 16'h0000);
    chk("m1a_rfsh", c_rfsh, 2 * D);
    chk("m1a_m1", c_m1, 2 * D);
    chk("m1a_merq", c_merq, 3 * D);
    chk("m1a_rdata", rdata, 8'h3E);
    run_txn(CMD_M1, 16'h1235, 8'h00, 1'b1);
    chk("m1b_rfsh_addr", rfsh_addr, 16'h0001);

    // Refresh counter wrap
    for (int i = 0; i < 126; i++) run_txn(CMD_M1, 16'h0100, 8'h00, 1'b1);
    chk("m1_rfsh_7f", rfsh_addr, 16'h007F);
    run_txn(CMD_M1, 16'h0100, 8'h00, 1'b1);
    chk("m1_rfsh_wrap", rfsh_addr, 16'h0000);

    // Soft reset during T2 of a write
    start_txn(CMD_MEM_WR, 16'h6000, 8'h09, 1'b1);
    guard = 0;
    while (bus_if.WR_n && guard < 64) begin
      @(negedge CLK);
      guard++;
    end
    chk("sr_wr_low", bus_if.WR_n, 0);
    SOFT_RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("sr_wr_high", bus_if.WR_n, 1);
    chk("sr_merq_high", bus_if.MERQ_n, 1);
    chk("sr_reset_n", bus_if.RESET_n, 0);
    chk("sr_ready", REQ_READY, 0);
    rsp_cnt = 0;
    for (int i = 0; i < 6 * D; i++) begin
      @(negedge CLK);
      if (RSP_VALID || REQ_READY) rsp_cnt++;
    end
    chk("sr_no_rsp_ready", rsp_cnt, 0);
    SOFT_RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("sr_release_ready", REQ_READY, 1);
    chk("sr_release_reset_n", bus_if.RESET_n, 1);
    rsp_cnt = 0;
    for (int i = 0; i < 6 * D; i++) begin
      @(negedge CLK);
      if (RSP_VALID) rsp_cnt++;
    end
    chk("sr_no_late_rsp", rsp_cnt, 0);

    // Asynchronous reset in the middle of a read
    start_txn(CMD_MEM_RD, 16'h8000, 8'h00, 1'b1);
    guard = 0;
    while (bus_if.RD_n && guard < 64) begin
      @(negedge CLK);
      guard++;
    end
    chk("ar_rd_low", bus_if.RD_n, 0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("ar_strobes", all_strobes(), 10'h3FF);
    chk("ar_addr", bus_if.ADDR, 16'h0000);
    chk("ar_reset_n", bus_if.RESET_n, 0);
    chk("ar_clk_en", bus_if.CLK_EN, 0);
    chk("ar_bus_clk", bus_if.CLK, 0);
    chk("ar_ready", REQ_READY, 0);
    chk("ar_rdata", RSP_RDATA, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("ar_release_ready", REQ_READY, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
